// File: rtl/canvas_layer_compositor_pkg.sv
// Shared types, register map offsets and control bit positions for the layer compositor.
package canvas_pkg;

  typedef logic [11:0] rgb12_t;

  localparam int LAYER_STRIDE = 16;
  localparam int OFF_W        = $clog2(LAYER_STRIDE);

  localparam logic [3:0] OFF_CTRL   = 4'h0;
  localparam logic [3:0] OFF_XS_LO  = 4'h1;
  localparam logic [3:0] OFF_XS_HI  = 4'h2;
  localparam logic [3:0] OFF_XE_LO  = 4'h3;
  localparam logic [3:0] OFF_XE_HI  = 4'h4;
  localparam logic [3:0] OFF_YS_LO  = 4'h5;
  localparam logic [3:0] OFF_YS_HI  = 4'h6;
  localparam logic [3:0] OFF_YE_LO  = 4'h7;
  localparam logic [3:0] OFF_YE_HI  = 4'h8;
  localparam logic [3:0] OFF_KEY_LO = 4'h9;
  localparam logic [3:0] OFF_KEY_HI = 4'hA;

  localparam logic [3:0] OFF_GCTRL   = 4'h0;
  localparam logic [3:0] OFF_STATUS  = 4'h1;
  localparam logic [3:0] OFF_FCNT_LO = 4'h2;
  localparam logic [3:0] OFF_FCNT_HI = 4'h3;
  localparam logic [3:0] OFF_BG_LO   = 4'h4;
  localparam logic [3:0] OFF_BG_HI   = 4'h5;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_DIM    = 1;
  localparam int CTRL_KEY_EN = 2;

  typedef struct packed {
    logic [2:0] ctrl;
    logic [9:0] xs;
    logic [9:0] xe;
    logic [9:0] ys;
    logic [9:0] ye;
    rgb12_t     key;
  } layer_cfg_t;

  // Halve each 4-bit channel independently.
  function automatic rgb12_t dim_rgb(input rgb12_t c);
    return (c >> 1) & 12'h777;
  endfunction

endpackage

// File: rtl/canvas_layer_compositor_if.sv
// Avalon-MM slave bus carrying all compositor programming traffic.
interface canvas_layer_compositor_if #(
  parameter int AW = 7
);
  logic          avl_cs;
  logic          avl_rden;
  logic          avl_wren;
  logic [AW-1:0] avl_addr;
  logic [7:0]    avl_wdata;
  logic [7:0]    avl_rdata;

  modport master (
    output avl_cs, avl_rden, avl_wren, avl_addr, avl_wdata,
    input  avl_rdata
  );

  modport slave (
    input  avl_cs, avl_rden, avl_wren, avl_addr, avl_wdata,
    output avl_rdata
  );
endinterface

// File: rtl/canvas_layer_compositor_hit.sv
// Window and transparency-key test for a single layer at the current pixel.
module canvas_layer_hit
  import canvas_pkg::*;
(
  input  logic       en,
  input  logic       key_en,
  input  logic [9:0] xs,
  input  logic [9:0] xe,
  input  logic [9:0] ys,
  input  logic [9:0] ye,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  rgb12_t     color,
  input  rgb12_t     key,
  output logic       hit
);
  // Half-open window; XS>=XE or YS>=YE naturally never matches.
  assign hit = en && (x >= xs) && (x < xe) && (y >= ys) && (y < ye)
               && !(key_en && (color == key));
endmodule

// File: rtl/canvas_layer_compositor.sv
// NLAYER-input priority compositor with shadowed per-layer windows committed at frame boundaries.
module canvas_layer_compositor
  import canvas_pkg::*;
#(
  parameter int NLAYER = 4,
  parameter int AW     = 7
) (
  input  logic                    clk,
  input  logic                    reset,
  canvas_layer_compositor_if.slave avl,
  input  logic [9:0]              draw_x,
  input  logic [9:0]              draw_y,
  input  logic                    frame_start,
  input  logic [NLAYER*12-1:0]    layer_color,
  output logic [3:0]              red,
  output logic [3:0]              green,
  output logic [3:0]              blue,
  output logic                    commit_done
);
  localparam int IW = AW - OFF_W;

  logic [IW-1:0]    sel;
  logic [OFF_W-1:0] off;
  layer_cfg_t       sh  [NLAYER];
  layer_cfg_t       act [NLAYER];
  logic             auto_commit, pending;
  logic [15:0]      frame_cnt;
  rgb12_t           bg;
  logic             wr_en, rd_en, glob_sel, layer_wr, set_pend;
  logic [7:0]       rd_mux;

  assign sel      = avl.avl_addr[AW-1:OFF_W];
  assign off      = avl.avl_addr[OFF_W-1:0];
  assign rd_en    = avl.avl_cs & avl.avl_rden;
  assign wr_en    = avl.avl_cs & avl.avl_wren & ~avl.avl_rden;
  assign glob_sel = (sel == IW'(NLAYER));
  assign layer_wr = wr_en && (sel < IW'(NLAYER)) && (off <= OFF_KEY_HI);
  assign set_pend = (layer_wr & auto_commit)
                  | (wr_en & glob_sel & (off == OFF_GCTRL) & avl.avl_wdata[0]);

  // The copy uses pre-edge shadow values, so a colliding write is excluded.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NLAYER; i++) begin
        sh[i]  <= '0;
        act[i] <= '0;
      end
      auto_commit <= 1'b0;
      pending     <= 1'b0;
      frame_cnt   <= '0;
      bg          <= '0;
      commit_done <= 1'b0;
    end else begin
      commit_done <= frame_start & pending;
      pending     <= set_pend | (pending & ~frame_start);
      if (frame_start) frame_cnt <= frame_cnt + 16'd1;
      for (int i = 0; i < NLAYER; i++) begin
        if (frame_start && pending) act[i] <= sh[i];
        if (wr_en && sel == IW'(i)) begin
          case (off)
            OFF_CTRL:   sh[i].ctrl       <= avl.avl_wdata[2:0];
            OFF_XS_LO:  sh[i].xs[7:0]    <= avl.avl_wdata;
            OFF_XS_HI:  sh[i].xs[9:8]    <= avl.avl_wdata[1:0];
            OFF_XE_LO:  sh[i].xe[7:0]    <= avl.avl_wdata;
            OFF_XE_HI:  sh[i].xe[9:8]    <= avl.avl_wdata[1:0];
            OFF_YS_LO:  sh[i].ys[7:0]    <= avl.avl_wdata;
            OFF_YS_HI:  sh[i].ys[9:8]    <= avl.avl_wdata[1:0];
            OFF_YE_LO:  sh[i].ye[7:0]    <= avl.avl_wdata;
            OFF_YE_HI:  sh[i].ye[9:8]    <= avl.avl_wdata[1:0];
            OFF_KEY_LO: sh[i].key[7:0]   <= avl.avl_wdata;
            OFF_KEY_HI: sh[i].key[11:8]  <= avl.avl_wdata[3:0];
            default: ;
          endcase
        end
      end
      if (wr_en && glob_sel) begin
        case (off)
          OFF_GCTRL: auto_commit <= avl.avl_wdata[1];
          OFF_BG_LO: bg[7:0]     <= avl.avl_wdata;
          OFF_BG_HI: bg[11:8]    <= avl.avl_wdata[3:0];
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NLAYER; i++) begin
      if (sel == IW'(i)) begin
        case (off)
          OFF_CTRL:   rd_mux = {5'b0, sh[i].ctrl};
          OFF_XS_LO:  rd_mux = sh[i].xs[7:0];
          OFF_XS_HI:  rd_mux = {6'b0, sh[i].xs[9:8]};
          OFF_XE_LO:  rd_mux = sh[i].xe[7:0];
          OFF_XE_HI:  rd_mux = {6'b0, sh[i].xe[9:8]};
          OFF_YS_LO:  rd_mux = sh[i].ys[7:0];
          OFF_YS_HI:  rd_mux = {6'b0, sh[i].ys[9:8]};
          OFF_YE_LO:  rd_mux = sh[i].ye[7:0];
          OFF_YE_HI:  rd_mux = {6'b0, sh[i].ye[9:8]};
          OFF_KEY_LO: rd_mux = sh[i].key[7:0];
          OFF_KEY_HI: rd_mux = {4'b0, sh[i].key[11:8]};
          default: ;
        endcase
      end
    end
    if (glob_sel) begin
      case (off)
        OFF_GCTRL:   rd_mux = {6'b0, auto_commit, 1'b0};
        OFF_STATUS:  rd_mux = {7'b0, pending};
        OFF_FCNT_LO: rd_mux = frame_cnt[7:0];
        OFF_FCNT_HI: rd_mux = frame_cnt[15:8];
        OFF_BG_LO:   rd_mux = bg[7:0];
        OFF_BG_HI:   rd_mux = {4'b0, bg[11:8]};
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     avl.avl_rdata <= '0;
    else if (rd_en) avl.avl_rdata <= rd_mux;
  end

  logic [NLAYER-1:0] hit, hit_q, dim_q;
  rgb12_t            col_q [NLAYER];
  rgb12_t            pix;

  for (genvar g = 0; g < NLAYER; g++) begin : g_hit
    canvas_layer_hit u_hit (
      .en     (act[g].ctrl[CTRL_EN]),
      .key_en (act[g].ctrl[CTRL_KEY_EN]),
      .xs     (act[g].xs),
      .xe     (act[g].xe),
      .ys     (act[g].ys),
      .ye     (act[g].ye),
      .x      (draw_x),
      .y      (draw_y),
      .color  (layer_color[12*g +: 12]),
      .key    (act[g].key),
      .hit    (hit[g])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hit_q <= '0;
      dim_q <= '0;
      for (int i = 0; i < NLAYER; i++) col_q[i] <= '0;
      {red, green, blue} <= '0;
    end else begin
      hit_q <= hit;
      for (int i = 0; i < NLAYER; i++) begin
        dim_q[i] <= act[i].ctrl[CTRL_DIM];
        col_q[i] <= layer_color[12*i +: 12];
      end
      {red, green, blue} <= pix;
    end
  end

  // Scan from the bottom layer up so the lowest-index hit wins.
  always_comb begin
    pix = bg;
    for (int i = NLAYER - 1; i >= 0; i--) begin
      if (hit_q[i]) pix = dim_q[i] ? dim_rgb(col_q[i]) : col_q[i];
    end
  end

endmodule

// File: tb/tb_canvas_layer_compositor.sv
// Self-checking bench for canvas_layer_compositor against a byte-level register/pixel model.
module tb_canvas_layer_compositor;
  localparam int NL = 4;
  localparam int AW = 7;
  localparam int G  = 16 * NL;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [9:0]        draw_x, draw_y;
  logic              frame_start;
  logic [NL*12-1:0]  layer_color;
  logic [3:0]        red, green, blue;
  logic              commit_done;

  always #5 clk = ~clk;

  canvas_layer_compositor_if #(.AW(AW)) avl ();

  canvas_layer_compositor #(.NLAYER(NL), .AW(AW)) dut (
    .clk         (clk),
    .reset       (reset),
    .avl         (avl),
    .draw_x      (draw_x),
    .draw_y      (draw_y),
    .frame_start (frame_start),
    .layer_color (layer_color),
    .red         (red),
    .green       (green),
    .blue        (blue),
    .commit_done (commit_done)
  );

  logic [7:0] m_sh  [128];
  logic [7:0] m_act [64];
  bit         m_pend, m_auto;
  int         m_fcnt;
  int         n_checks = 0, n_pass = 0, n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 128; i++) m_sh[i] = 8'h00;
    for (int i = 0; i < 64; i++) m_act[i] = 8'h00;
    m_pend = 0; m_auto = 0; m_fcnt = 0;
  endtask

  task automatic model_write(input int a, input logic [7:0] d);
    int o;
    o = a % 16;
    if (a < G) begin
      if (o <= 10) begin
        case (o)
          0:          m_sh[a] = d & 8'h07;
          2, 4, 6, 8: m_sh[a] = d & 8'h03;
          10:         m_sh[a] = d & 8'h0F;
          default:    m_sh[a] = d;
        endcase
        if (m_auto) m_pend = 1;
      end
    end else if (a == G) begin
      m_auto = d[1];
      if (d[0]) m_pend = 1;
    end else if (a == G + 4) m_sh[a] = d;
    else if (a == G + 5)     m_sh[a] = d & 8'h0F;
  endtask

  function automatic logic [7:0] model_read(input int a);
    if (a < G) return m_sh[a];
    if (a == G) return {6'b0, m_auto, 1'b0};
    if (a == G + 1) return {7'b0, m_pend};
    if (a == G + 2) return m_fcnt[7:0];
    if (a == G + 3) return m_fcnt[15:8];
    if (a == G + 4 || a == G + 5) return m_sh[a];
    return 8'h00;
  endfunction

  task automatic model_frame();
    if (m_pend) begin
      for (int i = 0; i < 64; i++) m_act[i] = m_sh[i];
      m_pend = 0;
    end
    m_fcnt = (m_fcnt + 1) % 65536;
  endtask

  // Pixel rule: first enabled layer whose window contains (x,y) and whose colour is not keyed out.
  function automatic logic [11:0] ref_pix(input int x, input int y, input logic [47:0] col);
    for (int i = 0; i < NL; i++) begin
      int b;
      int xs, xe, ys, ye;
      logic [11:0] key, c;
      b   = 16 * i;
      xs  = int'(m_act[b+1]) + 256 * int'(m_act[b+2]);
      xe  = int'(m_act[b+3]) + 256 * int'(m_act[b+4]);
      ys  = int'(m_act[b+5]) + 256 * int'(m_act[b+6]);
      ye  = int'(m_act[b+7]) + 256 * int'(m_act[b+8]);
      key = {m_act[b+10][3:0], m_act[b+9]};
      c   = col[12*i +: 12];
      if (m_act[b][0] && x >= xs && x < xe && y >= ys && y < ye && !(m_act[b][2] && c == key)) begin
        if (m_act[b][1]) return {4'(c[11:8] / 2), 4'(c[7:4] / 2), 4'(c[3:0] / 2)};
        return c;
      end
    end
    return {m_sh[G+5][3:0], m_sh[G+4]};
  endfunction

  task automatic wr(input int a, input logic [7:0] d);
    @(negedge clk);
    avl.avl_cs = 1; avl.avl_wren = 1; avl.avl_addr = a[AW-1:0]; avl.avl_wdata = d;
    model_write(a, d);
    @(negedge clk);
    avl.avl_cs = 0; avl.avl_wren = 0;
  endtask

  task automatic rd_check(input int a, input string tag);
    logic [7:0] exp;
    exp = model_read(a);
    @(negedge clk);
    avl.avl_cs = 1; avl.avl_rden = 1; avl.avl_addr = a[AW-1:0];
    @(negedge clk);
    avl.avl_cs = 0; avl.avl_rden = 0;
    check(tag, avl.avl_rdata, exp);
  endtask

  task automatic rdwr_check(input int a, input logic [7:0] d);
    logic [7:0] exp;
    exp = model_read(a);
    @(negedge clk);
    avl.avl_cs = 1; avl.avl_rden = 1; avl.avl_wren = 1; avl.avl_addr = a[AW-1:0]; avl.avl_wdata = d;
    @(negedge clk);
    avl.avl_cs = 0; avl.avl_rden = 0; avl.avl_wren = 0;
    check("rd_wins_over_wr", avl.avl_rdata, exp);
  endtask

  task automatic pulse_frame(input string tag);
    bit exp_cd;
    @(negedge clk);
    frame_start = 1;
    exp_cd = m_pend;
    model_frame();
    @(negedge clk);
    frame_start = 0;
    check(tag, commit_done, exp_cd);
  endtask

  task automatic wr_frame(input int a, input logic [7:0] d, input string tag);
    bit exp_cd;
    @(negedge clk);
    avl.avl_cs = 1; avl.avl_wren = 1; avl.avl_addr = a[AW-1:0]; avl.avl_wdata = d;
    frame_start = 1;
    exp_cd = m_pend;
    model_frame();
    model_write(a, d);
    @(negedge clk);
    avl.avl_cs = 0; avl.avl_wren = 0; frame_start = 0;
    check(tag, commit_done, exp_cd);
  endtask

  task automatic pix_one(input int x, input int y, input logic [47:0] col, input string tag,
                         output logic [11:0] obs);
    logic [11:0] exp;
    exp = ref_pix(x, y, col);
    @(negedge clk);
    draw_x = x[9:0]; draw_y = y[9:0]; layer_color = col;
    @(negedge clk);
    @(negedge clk);
    obs = {red, green, blue};
    check(tag, obs, exp);
  endtask

  function automatic logic [11:0] rand_col();
    case ($urandom_range(0, 3))
      0:       return 12'h000;
      1:       return 12'h555;
      default: return 12'($urandom);
    endcase
  endfunction

  task automatic pix_stream(input int n);
    logic [11:0] q[$];
    logic [47:0] col;
    int x, y;
    for (int k = 0; k < n + 2; k++) begin
      @(negedge clk);
      if (k >= 2) check("pix_stream", {red, green, blue}, q.pop_front());
      if (k < n) begin
        x = $urandom_range(0, 1023);
        y = $urandom_range(0, 1023);
        col = {rand_col(), rand_col(), rand_col(), rand_col()};
        draw_x = x[9:0]; draw_y = y[9:0]; layer_color = col;
        q.push_back(ref_pix(x, y, col));
      end
    end
  endtask

  logic [11:0] obs;
  int          a;

  initial begin
    avl.avl_cs = 0; avl.avl_rden = 0; avl.avl_wren = 0; avl.avl_addr = '0; avl.avl_wdata = '0;
    draw_x = '0; draw_y = '0; frame_start = 0; layer_color = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_rgb", {red, green, blue}, 12'h000);
    check("reset_commit_done", commit_done, 1'b0);
    reset = 1;

    for (int i = 0; i < 128; i++) rd_check(i, "reset_read");
    check("post_reset_rgb", {red, green, blue}, 12'h000);

    // Layer 0 window X 100..199, Y 50..99, background 0x123
    wr(G + 4, 8'h23); wr(G + 5, 8'h01);
    wr(0, 8'h01); wr(1, 8'd100); wr(2, 8'h00); wr(3, 8'd200); wr(4, 8'h00);
    wr(5, 8'd50); wr(6, 8'h00); wr(7, 8'd100); wr(8, 8'h00);
    rd_check(G + 1, "status_before_req");
    pix_one(150, 60, {36'h0, 12'hABC}, "pre_commit_bg", obs);
    check("pre_commit_bg_const", obs, 12'h123);
    wr(G, 8'h01);
    rd_check(G + 1, "status_after_req");
    rd_check(G, "gctrl_req_reads_0");
    pulse_frame("commit_done_pulse");
    @(negedge clk);
    check("commit_done_one_cycle", commit_done, 1'b0);
    rd_check(G + 1, "status_after_commit");
    pix_one(150, 60, {36'h0, 12'hABC}, "l0_hit", obs);
    check("l0_hit_const", obs, 12'hABC);
    pix_one(200, 60, {36'h0, 12'hABC}, "x_end_excl", obs);
    check("x_end_excl_const", obs, 12'h123);
    pix_one(199, 99, {36'h0, 12'hABC}, "last_incl", obs);
    pix_one(100, 50, {36'h0, 12'hABC}, "first_incl", obs);
    pix_one(99, 50, {36'h0, 12'hABC}, "x_before", obs);
    pix_one(150, 100, {36'h0, 12'hABC}, "y_end_excl", obs);

    // XE -> 300 without commit stays invisible
    wr(3, 8'h2C); wr(4, 8'h01);
    pulse_frame("no_commit_cd");
    rd_check(G + 1, "no_commit_status");
    pix_one(250, 60, {36'h0, 12'hABC}, "xe_unchanged", obs);
    check("xe_unchanged_const", obs, 12'h123);
    wr(G, 8'h01);
    pulse_frame("xe_commit_cd");
    pix_one(250, 60, {36'h0, 12'hABC}, "xe_new", obs);
    check("xe_new_const", obs, 12'hABC);

    // Layer 1 full screen; layer 0 keyed on 0x000
    wr(16, 8'h01); wr(19, 8'hFF); wr(20, 8'h03); wr(23, 8'hFF); wr(24, 8'h03);
    wr(0, 8'h05);
    wr(G, 8'h01);
    pulse_frame("key_commit_cd");
    pix_one(150, 60, {24'h0, 12'h3C5, 12'h000}, "key_hides_l0", obs);
    check("key_hides_l0_const", obs, 12'h3C5);
    pix_one(150, 60, {24'h0, 12'h3C5, 12'h001}, "key_mismatch", obs);
    wr(0, 8'h03);
    wr(G, 8'h01);
    pulse_frame("dim_commit_cd");
    pix_one(150, 60, {24'h0, 12'h3C5, 12'hF84}, "dim", obs);
    check("dim_const", obs, 12'h742);
    pix_one(400, 60, {24'h0, 12'h3C5, 12'hF84}, "l1_outside_l0", obs);

    // commit_req colliding with frame_start
    wr(0, 8'h00);
    wr_frame(G, 8'h01, "collide_req_cd");
    rd_check(G + 1, "collide_req_pending");
    pix_one(150, 60, {24'h0, 12'h3C5, 12'hF84}, "collide_no_copy", obs);
    check("collide_no_copy_const", obs, 12'h742);
    pulse_frame("collide_next_cd");
    pix_one(150, 60, {24'h0, 12'h3C5, 12'hF84}, "collide_copied", obs);
    check("collide_copied_const", obs, 12'h3C5);

    // Plain layer write colliding with a pending commit is excluded from the copy
    wr(G, 8'h01);
    wr_frame(0, 8'h01, "collide_lw_cd");
    rd_check(G + 1, "collide_lw_pending");
    pix_one(150, 60, {24'h0, 12'h3C5, 12'hF84}, "collide_lw_excl", obs);
    wr(G, 8'h01);
    pulse_frame("collide_lw_later_cd");
    pix_one(150, 60, {24'h0, 12'h3C5, 12'hF84}, "collide_lw_later", obs);

    // auto_commit
    wr(G, 8'h02);
    rd_check(G, "gctrl_auto");
    wr(0, 8'h03);
    rd_check(G + 1, "auto_pending");
    pulse_frame("auto_cd");
    pix_one(150, 60, {24'h0, 12'h3C5, 12'hF84}, "auto_dim", obs);
    wr_frame(1, 8'd90, "auto_collide_cd");
    rd_check(G + 1, "auto_collide_pending");
    pulse_frame("auto_collide_next_cd");
    wr(G, 8'h00);

    // Layer 2 keyed on 0x555, then random pixels
    wr(32, 8'h05); wr(35, 8'h90); wr(36, 8'h01); wr(39, 8'd200); wr(41, 8'h55); wr(42, 8'h05);
    wr(G, 8'h01);
    pulse_frame("l2_commit_cd");
    pix_stream(200);

    // Random register traffic
    for (int k = 0; k < 150; k++) begin
      a = $urandom_range(0, 127);
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: wr(a, 8'($urandom));
        5, 6:          rd_check(a, "rand_read");
        7:             rdwr_check(a, 8'($urandom));
        8:             pulse_frame("rand_frame_cd");
        default:       wr_frame(a, 8'($urandom), "rand_collide_cd");
      endcase
    end
    for (int i = 0; i < 128; i++) rd_check(i, "rand_readback");
    wr(G, 8'h01);
    pulse_frame("rand_commit_cd");
    pix_stream(150);

    // Asynchronous reset during a pixel stream
    pix_stream(5);
    @(negedge clk);
    draw_x = 10'd150; draw_y = 10'd60; layer_color = {24'h0, 12'h3C5, 12'hF84};
    #2 reset = 0;
    #1 check("reset_async_rgb", {red, green, blue}, 12'h000);
    @(negedge clk);
    check("reset_hold_rgb", {red, green, blue}, 12'h000);
    check("reset_hold_cd", commit_done, 1'b0);
    model_reset();
    reset = 1;
    rd_check(0, "post_reset_ctrl");
    rd_check(G + 4, "post_reset_bg");
    rd_check(G + 2, "post_reset_fcnt");
    pix_one(150, 60, {24'h0, 12'h3C5, 12'hF84}, "post_reset_pix", obs);
    check("post_reset_pix_const", obs, 12'h000);

    // frame_cnt wrap
    @(negedge clk);
    frame_start = 1;
    repeat (65535) begin
      @(negedge clk);
      model_frame();
    end
    frame_start = 0;
    rd_check(G + 2, "fcnt_ffff_lo");
    rd_check(G + 3, "fcnt_ffff_hi");
    check("fcnt_model_ffff", m_fcnt, 32'd65535);
    pulse_frame("wrap_cd");
    rd_check(G + 2, "fcnt_wrap_lo");
    rd_check(G + 3, "fcnt_wrap_hi");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
